mon_ctrl_rx: RTL and testbench

//  Receive end of the cyclic monitoring transfer. Sits at the destination router's

---
 rtl/mon_ctrl_rx_pkg.sv | 45 ++++
 rtl/mon_map_ram.sv | 31 +++
 rtl/mon_ctrl_rx.sv | 158 +++++++++++++++
 tb/tb_mon_ctrl_rx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mon_ctrl_rx_pkg.sv
// Shared types, header field layout and map geometry for the monitoring-transfer receiver.
package mon_ctrl_rx_pkg;

  localparam int unsigned G_PORTS           = 5;
  localparam int unsigned G_VCS             = 4;
  localparam int unsigned G_NO_OF_HISTORIES = 2;

  localparam int unsigned FLIT_W  = 16;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NPLD    = (DATA_W + FLIT_W - 1) / FLIT_W;
  localparam int unsigned SHIFT_W = NPLD * FLIT_W;
  localparam int unsigned MAP_W   = 8;
  localparam int unsigned ENTRIES = 3 * G_PORTS * G_VCS * G_NO_OF_HISTORIES;
  localparam int unsigned AW      = $clog2(ENTRIES);
  localparam int unsigned CNT_W   = $clog2(NPLD + 1);

  localparam int unsigned KIND_LSB = 14;
  localparam int unsigned KIND_W   = 2;
  localparam int unsigned PORT_LSB = 11;
  localparam int unsigned PORT_W   = 3;
  localparam int unsigned VC_LSB   = 9;
  localparam int unsigned VC_W     = 2;
  localparam int unsigned HIST_LSB = 8;
  localparam int unsigned HIST_W   = 1;

  localparam logic [PORT_W-1:0] NUM_PORTS = PORT_W'(G_PORTS);

  typedef enum logic [KIND_W-1:0] {MON_RVC, MON_BFL, MON_OPR, MON_RSVD} mon_kind_e;

  function automatic logic [AW-1:0] mon_idx(mon_kind_e kind, logic [PORT_W-1:0] port,
                                            logic [VC_W-1:0] vc, logic [HIST_W-1:0] hist);
    int unsigned k, p, c, h, v;
    k = 32'(kind);
    p = 32'(port);
    c = 32'(vc);
    h = 32'(hist);
    v = ((k * G_PORTS + p) * G_VCS + c) * G_NO_OF_HISTORIES + h;
    return v[AW-1:0];
  endfunction

  function automatic logic [MAP_W-1:0] mon_sat(logic [DATA_W-1:0] v);
    return (|v[DATA_W-1:MAP_W]) ? '1 : v[MAP_W-1:0];
  endfunction

endpackage

// File: rtl/mon_map_ram.sv
// Simple dual-port map storage: one write port, one registered read port.
module mon_map_ram #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 120,
  localparam int unsigned Aw   = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [Aw-1:0]    waddr,
  input  logic [Width-1:0] wdata,
  input  logic [Aw-1:0]    raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem [Depth];

  // Storage itself has no reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= (32'(raddr) < Depth) ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/mon_ctrl_rx.sv
// Monitoring-message receiver: reassembles ctrl flits and writes saturated values to the map.
// Optional peak tracking array enabled by defining MON_RX_PEAK_EN.
module mon_ctrl_rx
  import mon_ctrl_rx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flit_valid,
  input  logic [FLIT_W-1:0] flit_data,
  output logic              flit_ready,
  input  logic [AW-1:0]     rd_addr,
  output logic [MAP_W-1:0]  rd_data,
  output logic              upd_valid,
  output logic [AW-1:0]     upd_idx,
  output logic [7:0]        err_cnt,
  input  logic              peak_clr,
  output logic [MAP_W-1:0]  peak_rd_data
);

  typedef enum logic [1:0] {StIdle, StPayload, StDrop, StCommit} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [7:0]         err_q, err_d;
  logic               upd_valid_q;
  logic [AW-1:0]      upd_idx_q;
  logic               wr_en;
  logic [MAP_W-1:0]   wr_data;

  mon_kind_e          hdr_kind;
  logic [PORT_W-1:0]  hdr_port;
  logic [VC_W-1:0]    hdr_vc;
  logic [HIST_W-1:0]  hdr_hist;
  logic               hdr_bad;
  logic [AW-1:0]      hdr_idx;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(NPLD - 1);

  always_comb begin
    hdr_kind = mon_kind_e'(flit_data[KIND_LSB +: KIND_W]);
    hdr_port = flit_data[PORT_LSB +: PORT_W];
    hdr_vc   = (hdr_kind == MON_OPR) ? '0 : flit_data[VC_LSB +: VC_W];
    hdr_hist = flit_data[HIST_LSB +: HIST_W];
    hdr_bad  = (hdr_kind == MON_RSVD) || (hdr_port >= NUM_PORTS);
    hdr_idx  = mon_idx(hdr_kind, hdr_port, hdr_vc, hdr_hist);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    flit_ready = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (flit_valid) begin
          cnt_d = '0;
          if (hdr_bad) begin
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
            state_d = StDrop;
          end else begin
            idx_d   = hdr_idx;
            shift_d = '0;
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (flit_valid) begin
          shift_d = (shift_q << FLIT_W) | SHIFT_W'(flit_data);
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CntLast) state_d = StCommit;
        end
      end
      StDrop: begin
        if (flit_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CntLast) state_d = StIdle;
        end
      end
      StCommit: begin
        flit_ready = 1'b0;
        wr_en      = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign wr_data = mon_sat(shift_q[DATA_W-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      idx_q       <= '0;
      err_q       <= '0;
      upd_valid_q <= 1'b0;
      upd_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      upd_valid_q <= wr_en;
      if (wr_en) upd_idx_q <= idx_q;
    end
  end

  assign upd_valid = upd_valid_q;
  assign upd_idx   = upd_idx_q;
  assign err_cnt   = err_q;

  mon_map_ram #(
    .Width(MAP_W),
    .Depth(ENTRIES)
  ) u_map_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr_en),
    .waddr(idx_q),
    .wdata(wr_data),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

`ifdef MON_RX_PEAK_EN
  logic [MAP_W-1:0] peak_q [ENTRIES];
  logic [MAP_W-1:0] peak_rd_q;

  // A clear coinciding with a commit still keeps the committed value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) peak_q[i] <= '0;
      peak_rd_q <= '0;
    end else begin
      if (peak_clr) begin
        for (int i = 0; i < int'(ENTRIES); i++) peak_q[i] <= '0;
      end
      if (wr_en && (peak_clr || (wr_data > peak_q[idx_q]))) peak_q[idx_q] <= wr_data;
      peak_rd_q <= (32'(rd_addr) < ENTRIES) ? peak_q[rd_addr] : '0;
    end
  end

  assign peak_rd_data = peak_rd_q;
`else
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
  assign peak_rd_data    = '0;
`endif

endmodule

// File: tb/tb_mon_ctrl_rx.sv
// Directed bench for mon_ctrl_rx: vector table plus hand-written multi-cycle sequences.
module tb_mon_ctrl_rx;
  import mon_ctrl_rx_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              flit_valid;
  logic [FLIT_W-1:0] flit_data;
  logic              flit_ready;
  logic [AW-1:0]     rd_addr;
  logic [MAP_W-1:0]  rd_data;
  logic              upd_valid;
  logic [AW-1:0]     upd_idx;
  logic [7:0]        err_cnt;
  logic              peak_clr;
  logic [MAP_W-1:0]  peak_rd_data;

  int n_cmp  = 0;
  int n_fail = 0;
  int upd_seen = 0;
  logic [AW-1:0] last_upd_idx = '0;

  always #5 clk = ~clk;

  mon_ctrl_rx dut (
    .clk         (clk),
    .rst         (rst),
    .flit_valid  (flit_valid),
    .flit_data   (flit_data),
    .flit_ready  (flit_ready),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .upd_valid   (upd_valid),
    .upd_idx     (upd_idx),
    .err_cnt     (err_cnt),
    .peak_clr    (peak_clr),
    .peak_rd_data(peak_rd_data)
  );

  always @(negedge clk) begin
    if (upd_valid) begin
      upd_seen++;
      last_upd_idx = upd_idx;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0]   hdr;
    logic [15:0]   p0;
    logic [15:0]   p1;
    int            exp_upd;
    logic [AW-1:0] exp_idx;
    logic [AW-1:0] rd_a;
    logic [7:0]    exp_rd;
    logic [7:0]    exp_err;
  } vec_t;

  function automatic logic [15:0] mkhdr(int k, int p, int v, int h);
    logic [15:0] r;
    r        = '0;
    r[15:14] = k[1:0];
    r[13:11] = p[2:0];
    r[10:9]  = v[1:0];
    r[8]     = h[0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at #1 after a posedge; returns at #1 after the accepting edge.
  task automatic send_flit(input logic [15:0] d);
    flit_valid = 1'b1;
    flit_data  = d;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (flit_ready) begin
        @(posedge clk);
        #1;
        flit_valid = 1'b0;
        return;
      end
    end
    flit_valid = 1'b0;
    n_cmp++;
    n_fail++;
    $display("FAIL send_flit: flit_ready stayed 0 for 20 cycles, expected 1");
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [AW-1:0] a, output logic [7:0] d, output logic [7:0] pk);
    rd_addr = a;
    @(posedge clk);
    #1;
    d  = rd_data;
    pk = peak_rd_data;
  endtask

  vec_t vecs[8];
  logic [7:0] d, pk;
  int u0, nlow;

  initial begin
    vecs[0] = '{mkhdr(1, 2, 1, 0), 16'h0000, 16'h0042, 1, 7'd58,  7'd58,  8'h42, 8'd0};
    vecs[1] = '{mkhdr(1, 2, 1, 0), 16'h0001, 16'h0000, 1, 7'd58,  7'd58,  8'hFF, 8'd0};
    vecs[2] = '{mkhdr(3, 0, 0, 0), 16'h1234, 16'h5678, 0, 7'd0,   7'd58,  8'hFF, 8'd1};
    vecs[3] = '{mkhdr(1, 2, 1, 0), 16'h0000, 16'h0042, 1, 7'd58,  7'd58,  8'h42, 8'd1};
    vecs[4] = '{mkhdr(1, 7, 0, 0), 16'h0000, 16'h0011, 0, 7'd0,   7'd58,  8'h42, 8'd2};
    vecs[5] = '{mkhdr(2, 4, 3, 1), 16'h0000, 16'h00FE, 1, 7'd113, 7'd113, 8'hFE, 8'd2};
    vecs[6] = '{mkhdr(0, 0, 0, 0), 16'h8000, 16'h0000, 1, 7'd0,   7'd0,   8'hFF, 8'd2};
    vecs[7] = '{mkhdr(1, 4, 3, 1), 16'h0000, 16'h0080, 1, 7'd79,  7'd79,  8'h80, 8'd2};

    rst        = 1'b1;
    flit_valid = 1'b0;
    flit_data  = '0;
    rd_addr    = '0;
    peak_clr   = 1'b0;
    idle(2);
    chk("reset flit_ready", 32'(flit_ready), 32'd1);
    chk("reset upd_valid", 32'(upd_valid), 32'd0);
    chk("reset upd_idx", 32'(upd_idx), 32'd0);
    chk("reset err_cnt", 32'(err_cnt), 32'd0);
    chk("reset rd_data", 32'(rd_data), 32'd0);
    chk("reset peak_rd_data", 32'(peak_rd_data), 32'd0);
    rst = 1'b0;
    idle(1);

    for (int i = 0; i < 8; i++) begin
      u0 = upd_seen;
      send_flit(vecs[i].hdr);
      send_flit(vecs[i].p0);
      send_flit(vecs[i].p1);
      idle(3);
      chk($sformatf("vec%0d upd count", i), 32'(upd_seen - u0), 32'(vecs[i].exp_upd));
      if (vecs[i].exp_upd != 0)
        chk($sformatf("vec%0d upd_idx", i), 32'(last_upd_idx), 32'(vecs[i].exp_idx));
      rd(vecs[i].rd_a, d, pk);
      chk($sformatf("vec%0d rd_data", i), 32'(d), 32'(vecs[i].exp_rd));
      chk($sformatf("vec%0d err_cnt", i), 32'(err_cnt), 32'(vecs[i].exp_err));
    end

    // Gapped flits, next header held valid through the commit cycle.
    u0 = upd_seen;
    send_flit(mkhdr(1, 2, 1, 0));
    idle(3);
    send_flit(16'h0000);
    idle(3);
    send_flit(16'h0037);
    flit_valid = 1'b1;
    flit_data  = mkhdr(0, 1, 0, 0);
    nlow = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (!flit_ready) nlow++;
      else break;
    end
    @(posedge clk);
    #1;
    flit_valid = 1'b0;
    chk("gap ready low cycles", 32'(nlow), 32'd1);
    send_flit(16'h0000);
    send_flit(16'h0022);
    idle(3);
    chk("gap upd count", 32'(upd_seen - u0), 32'd2);
    chk("gap last upd_idx", 32'(last_upd_idx), 32'd8);
    rd(7'd58, d, pk);
    chk("gap rd 58", 32'(d), 32'h37);
    rd(7'd8, d, pk);
    chk("gap rd 8", 32'(d), 32'h22);

    // Reset mid-message discards the partial message.
    send_flit(mkhdr(1, 2, 1, 0));
    send_flit(16'h0000);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    u0 = upd_seen;
    send_flit(mkhdr(0, 0, 0, 0));
    send_flit(16'h0000);
    send_flit(16'h0005);
    idle(3);
    chk("rst upd count", 32'(upd_seen - u0), 32'd1);
    chk("rst upd_idx", 32'(last_upd_idx), 32'd0);
    rd(7'd0, d, pk);
    chk("rst rd 0", 32'(d), 32'h05);
    rd(7'd58, d, pk);
    chk("rst rd 58", 32'(d), 32'h37);
    chk("rst err_cnt", 32'(err_cnt), 32'd0);

`ifdef MON_RX_PEAK_EN
    peak_clr = 1'b1;
    idle(1);
    peak_clr = 1'b0;
    send_flit(mkhdr(1, 2, 1, 0));
    send_flit(16'h0000);
    send_flit(16'h0030);
    send_flit(mkhdr(1, 2, 1, 0));
    send_flit(16'h0000);
    send_flit(16'h0010);
    idle(3);
    rd(7'd58, d, pk);
    chk("peak rd 58", 32'(d), 32'h10);
    chk("peak value 58", 32'(pk), 32'h30);
    peak_clr = 1'b1;
    idle(1);
    peak_clr = 1'b0;
    rd(7'd58, d, pk);
    chk("peak after clr", 32'(pk), 32'h00);
`else
    rd(7'd58, d, pk);
    chk("peak tied zero", 32'(pk), 32'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
